// File: rtl/binary_shift_pkg.sv
// Shared definitions for the binary shift datapath: shift direction encoding
// and the deserializer output-buffer state.
package binary_shift_pkg;

   localparam logic SHIFT_LEFT  = 1'b1;
   localparam logic SHIFT_RIGHT = 1'b0;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } out_state_e;

endpackage

// File: rtl/binary_shift_stage.sv
// WIDTH-bit serial-in shift register. sh_nxt exposes the post-shift value so the
// caller can capture a word on the same edge its last bit is shifted in.
module binary_shift_stage
   import binary_shift_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             en,
   input  logic             dir,
   input  logic             sin,
   output logic [WIDTH-1:0] sh,
   output logic [WIDTH-1:0] sh_nxt
);

   logic [WIDTH-1:0] sh_q, sh_d;

   always_comb begin
      sh_nxt = (dir == SHIFT_LEFT) ? {sh_q[WIDTH-2:0], sin} : {sin, sh_q[WIDTH-1:1]};
      sh_d   = sh_q;
      if (clr)     sh_d = '0;
      else if (en) sh_d = sh_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sh_q <= '0;
      else        sh_q <= sh_d;
   end

   assign sh = sh_q;

endmodule

// File: rtl/binary_shift_deserializer.sv
// Serial-to-parallel receiver: assembles WIDTH-bit words one bit per strobe and
// holds each finished word in a one-entry output buffer with valid/ready.
module binary_shift_deserializer
   import binary_shift_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             SIN,
   input  logic             SVALID,
   input  logic             D,
   input  logic             CLR,
   output logic [WIDTH-1:0] S,
   output logic             OVALID,
   input  logic             ORDY,
   output logic             OVERRUN
);

   localparam int             CW      = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0]  CNT_MAX = CW'(WIDTH - 1);

   logic [CW-1:0]    cnt_q, cnt_d;
   logic             dl_q, dl_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic             overrun_q, overrun_d;
   out_state_e       state_q, state_d;

   logic             accept, first_bit, complete, dir_eff;
   logic [WIDTH-1:0] sh, sh_nxt;

   // CLR wins over a simultaneous strobe, so that bit never reaches the datapath.
   assign accept    = SVALID && !CLR;
   assign first_bit = (cnt_q == '0);
   assign complete  = accept && (cnt_q == CNT_MAX);
   assign dir_eff   = first_bit ? D : dl_q;

   binary_shift_stage #(.WIDTH(WIDTH)) u_stage (
      .clk    (CLK),
      .rst_n  (RST_N),
      .clr    (CLR),
      .en     (accept),
      .dir    (dir_eff),
      .sin    (SIN),
      .sh     (sh),
      .sh_nxt (sh_nxt)
   );

   always_comb begin
      cnt_d = cnt_q;
      dl_d  = dl_q;
      if (CLR) begin
         cnt_d = '0;
      end else if (accept) begin
         cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CW'(1);
         if (first_bit) dl_d = D;
      end
   end

   always_comb begin
      state_d   = state_q;
      s_d       = s_q;
      overrun_d = CLR ? 1'b0 : overrun_q;
      unique case (state_q)
         EMPTY: begin
            if (complete) begin
               s_d     = sh_nxt;
               state_d = FULL;
            end
         end
         FULL: begin
            // A word finishing on the same edge it is consumed replaces it losslessly.
            if (complete && ORDY)  s_d = sh_nxt;
            else if (complete)     overrun_d = 1'b1;
            else if (ORDY)         state_d = EMPTY;
         end
         default: state_d = EMPTY;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         cnt_q     <= '0;
         dl_q      <= 1'b0;
         s_q       <= '0;
         overrun_q <= 1'b0;
         state_q   <= EMPTY;
      end else begin
         cnt_q     <= cnt_d;
         dl_q      <= dl_d;
         s_q       <= s_d;
         overrun_q <= overrun_d;
         state_q   <= state_d;
      end
   end

   assign S       = s_q;
   assign OVALID  = (state_q == FULL);
   assign OVERRUN = overrun_q;

   logic unused_sh;
   assign unused_sh = ^sh;

endmodule
